// File: rtl/axi_write_burst_channel_pkg.sv
// Shared definitions for the AXI4 write burst engine of the DDR-backed FIFO.
// Holds the FSM state encoding, the clogb2 helper used to size the beat
// counter, and the burst-size helper used for address stepping.
package axi_write_burst_channel_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StResp = 2'd3
  } wr_state_e;

  // Number of bits needed to represent value (0 for value == 0).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((value >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  // Bytes covered by one burst.
  function automatic int unsigned burst_bytes(input int unsigned burst_len,
                                               input int unsigned data_width);
    return burst_len * data_width / 8;
  endfunction

endpackage

// File: rtl/axi_write_burst_channel.sv
// AXI4 write-side master engine for the DDR FIFO.
// Drains one fixed-length burst per request from an upstream FWFT buffer onto
// AW/W, then waits for the B response. Burst start addresses increase linearly.
//
// Optional feature: define AXI_WR_ADDR_WRAP_EN to wrap the write pointer to 0
// when the next burst would reach C_WR_ADDR_LIMIT (ring buffer over a DDR
// sub-region). Without it the address wraps naturally at 2**ADDR_W.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN  clock, synchronous active-low reset
//   wr_en                      upstream buffer holds at least one full burst
//   fifo_dout / fifo_rd        FWFT head word / pop
//   M_AXI_AW*                  write address channel (master side)
//   M_AXI_W*                   write data channel (WSTRB constant all-ones)
//   M_AXI_B*                   write response channel
//   burst_done                 one-cycle pulse on the B handshake
//   wr_error                   sticky, set on any non-OKAY BRESP
module axi_write_burst_channel
  import axi_write_burst_channel_pkg::*;
#(
  parameter int unsigned     C_M_AXI_ADDR_WIDTH = 30,
  parameter int unsigned     C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned     C_M_AXI_BURST_LEN  = 16,
  parameter longint unsigned C_WR_ADDR_LIMIT    = 64'h4000_0000
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            wr_en,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   fifo_dout,
  output logic                            fifo_rd,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  output logic                            M_AXI_WLAST,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  output logic                            burst_done,
  output logic                            wr_error
);

  localparam int unsigned AddrW      = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned BurstBytes = burst_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH);
  localparam int unsigned CntRaw     = clogb2(C_M_AXI_BURST_LEN - 1);
  localparam int unsigned CntW       = (CntRaw < 1) ? 1 : CntRaw;

  localparam logic [CntW-1:0]  LastBeat = CntW'(C_M_AXI_BURST_LEN - 1);
  localparam logic [AddrW-1:0] AddrStep = AddrW'(BurstBytes);

  // A limit that is not burst-aligned would let a burst straddle the wrap point.
  if ((C_WR_ADDR_LIMIT % BurstBytes) != 0) begin : g_limit_check
    $error("C_WR_ADDR_LIMIT must be a multiple of the burst size");
  end

  wr_state_e        state_q, state_d;
  logic [AddrW-1:0] awaddr_q, awaddr_d;
  logic [AddrW-1:0] addr_next;
  logic [CntW-1:0]  beat_q, beat_d;
  logic             wr_error_q, wr_error_d;
  logic             aw_valid, w_valid, b_ready, done;
  logic             last_beat;

`ifdef AXI_WR_ADDR_WRAP_EN
  localparam logic [AddrW:0] WrapLimit = (AddrW + 1)'(C_WR_ADDR_LIMIT);
  logic [AddrW:0] addr_sum;

  // One extra bit so a limit of exactly 2**ADDR_W still compares correctly.
  assign addr_sum  = {1'b0, awaddr_q} + {1'b0, AddrStep};
  assign addr_next = (addr_sum >= WrapLimit) ? '0 : addr_sum[AddrW-1:0];
`else
  assign addr_next = awaddr_q + AddrStep;
`endif

  assign last_beat = (beat_q == LastBeat);

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= StIdle;
      awaddr_q   <= '0;
      beat_q     <= '0;
      wr_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      beat_q     <= beat_d;
      wr_error_q <= wr_error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    beat_d     = beat_q;
    wr_error_d = wr_error_q;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    b_ready    = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_en) state_d = StAddr;
      end
      StAddr: begin
        aw_valid = 1'b1;
        // Address advances only after the handshake, so AWADDR is stable while valid.
        if (M_AXI_AWREADY) begin
          awaddr_d = addr_next;
          state_d  = StData;
        end
      end
      StData: begin
        w_valid = 1'b1;
        if (M_AXI_WREADY) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = StResp;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StResp: begin
        b_ready = 1'b1;
        if (M_AXI_BVALID) begin
          done       = 1'b1;
          wr_error_d = wr_error_q | (M_AXI_BRESP != 2'b00);
          state_d    = StIdle;
        end
      end
    endcase
  end

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = aw_valid;
  // FWFT head passes straight through; it only moves on a pop, so it holds under stall.
  assign M_AXI_WDATA   = w_valid ? fifo_dout : '0;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_WLAST   = w_valid & last_beat;
  assign fifo_rd       = w_valid & M_AXI_WREADY;
  assign M_AXI_BREADY  = b_ready;
  assign burst_done    = done;
  assign wr_error      = wr_error_q;

endmodule

// File: tb/tb_axi_write_burst_channel.sv
// Directed self-checking bench for axi_write_burst_channel (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_axi_write_burst_channel;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 64;
  localparam int unsigned BL = 16;
`ifdef AXI_WR_ADDR_WRAP_EN
  localparam longint unsigned Limit = 64'h200;
`else
  localparam longint unsigned Limit = 64'h4000_0000;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wvalid;
  logic          wready = 1'b0;
  logic          wlast;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [1:0]    bresp = 2'b00;
  logic          burst_done;
  logic          wr_error;

  int            total = 0;
  int            bad = 0;
  logic [31:0]   head = 32'd0;
  logic [31:0]   exp_pops = 32'd0;
  logic          exp_err = 1'b0;
  logic [AW-1:0] a;

  always #5 clk = ~clk;

  // Upstream FWFT buffer model: head word advances on every pop the DUT issues.
  always @(posedge clk) if (fifo_rd === 1'b1) head <= head + 32'd1;
  assign fifo_dout = {32'hC0DE_0000, head};

  axi_write_burst_channel #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_BURST_LEN (BL),
    .C_WR_ADDR_LIMIT   (Limit)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rstn),
    .wr_en        (wr_en),
    .fifo_dout    (fifo_dout),
    .fifo_rd      (fifo_rd),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_WLAST  (wlast),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_BRESP  (bresp),
    .burst_done   (burst_done),
    .wr_error     (wr_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] cur);
    logic [AW:0] sum;
    sum = {1'b0, cur} + 31'h80;
`ifdef AXI_WR_ADDR_WRAP_EN
    return (sum >= Limit) ? '0 : sum[AW-1:0];
`else
    return sum[AW-1:0];
`endif
  endfunction

  // One full burst starting from IDLE; ends one cycle into the following IDLE.
  // abort_at != 0 returns in DATA right after that many beats have been accepted.
  task automatic run_burst(input logic [AW-1:0] exp_addr, input int aw_stall,
                           input bit toggle, input logic [1:0] resp, input bit keep,
                           input int abort_at);
    int beat;
    int cyc;
    wr_en = 1'b1; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    #1;
    chk("idle_awvalid", awvalid, 1'b0);
    step();
    if (!keep) wr_en = 1'b0;
    for (int k = 0; k < aw_stall; k++) begin
      #1;
      chk("aw_stall_valid", awvalid, 1'b1);
      chk("aw_stall_addr", awaddr, exp_addr);
      chk("w_before_aw", wvalid, 1'b0);
      step();
    end
    awready = 1'b1;
    #1;
    chk("aw_valid", awvalid, 1'b1);
    chk("aw_addr", awaddr, exp_addr);
    chk("w_before_aw", wvalid, 1'b0);
    step();
    awready = 1'b0;
    beat = 0;
    cyc = 0;
    while (beat < BL && cyc < 200) begin
      wready = toggle ? ((cyc % 3) == 0) : 1'b1;
      #1;
      chk("wvalid", wvalid, 1'b1);
      chk("wdata", wdata, {32'hC0DE_0000, exp_pops});
      chk("fifo_rd", fifo_rd, wready);
      chk("wlast", wlast, beat == BL - 1);
      chk("aw_dropped", awvalid, 1'b0);
      if (wready) begin
        beat++;
        exp_pops++;
      end
      if (abort_at != 0 && beat == abort_at) begin
        step();
        wready = 1'b0;
        return;
      end
      step();
      cyc++;
    end
    chk("beats_in_budget", beat, BL);
    wready = 1'b0;
    bvalid = 1'b1;
    bresp = resp;
    #1;
    chk("bready", bready, 1'b1);
    chk("wvalid_after_last", wvalid, 1'b0);
    chk("burst_done_pulse", burst_done, 1'b1);
    chk("wr_error_before_b", wr_error, exp_err);
    step();
    bvalid = 1'b0;
    bresp = 2'b00;
    exp_err = exp_err | (resp != 2'b00);
    chk("burst_done_single", burst_done, 1'b0);
    chk("wr_error_after_b", wr_error, exp_err);
    chk("idle_gap_awvalid", awvalid, 1'b0);
    chk("bready_idle", bready, 1'b0);
    chk("aw_addr_next", awaddr, next_addr(exp_addr));
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_burst_done", burst_done, 1'b0);
    chk("rst_wr_error", wr_error, 1'b0);
    chk("rst_awaddr", awaddr, 30'h0);
    chk("rst_wdata", wdata, 64'h0);
    chk("rst_wstrb", wstrb, 8'hFF);
    rstn = 1'b1;

    // Basic burst: address 0, then 0x80
    run_burst(30'h0, 0, 1'b0, 2'b00, 1'b0, 0);
    chk("basic_pops", head, 32'd16);
    chk("basic_next_addr", awaddr, 30'h80);
    // wr_en low: no new burst
    step();
    chk("no_req_awvalid", awvalid, 1'b0);
    step();
    chk("no_req_awvalid2", awvalid, 1'b0);

    // Backpressure: AWREADY low 5 cycles, WREADY 1,0,0,1,...
    run_burst(30'h80, 5, 1'b1, 2'b00, 1'b0, 0);
    chk("bp_pops", head, 32'd32);
    chk("bp_next_addr", awaddr, 30'h100);

    // Fresh reset, then back-to-back bursts with SLVERR on the second
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    exp_err = 1'b0;
    chk("rst2_awaddr", awaddr, 30'h0);
    a = 30'h0;
    for (int i = 0; i < 5; i++) begin
      run_burst(a, 0, 1'b0, (i == 1) ? 2'b10 : 2'b00, i < 4, 0);
      a = next_addr(a);
    end
`ifdef AXI_WR_ADDR_WRAP_EN
    chk("wrap_final_addr", awaddr, 30'h80);
`else
    chk("linear_final_addr", awaddr, 30'h280);
`endif
    chk("b2b_pops", head, 32'd112);
    chk("err_sticky", wr_error, 1'b1);

    // Reset asserted mid-DATA after beat 7
    run_burst(a, 0, 1'b0, 2'b00, 1'b0, 7);
    rstn = 1'b0;
    step();
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_awaddr", awaddr, 30'h0);
    chk("mid_rst_wr_error", wr_error, 1'b0);
    chk("mid_rst_fifo_rd", fifo_rd, 1'b0);
    chk("mid_rst_pops", head, 32'd119);
    rstn = 1'b1;
    exp_err = 1'b0;
    run_burst(30'h0, 0, 1'b0, 2'b00, 1'b0, 0);
    chk("post_rst_pops", head, 32'd135);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
